uart_alu_core: RTL and testbench
================================

Name: uart_alu_core

Overview:
- Byte-stream command processor between the uart_rx master stream and the uart_tx slave stream of the UART ALU.
- Parses framed command packets from the receive stream, echoes payload or computes a 32-bit arithmetic result, and streams response bytes to the transmitter.
- Both sides use AXI-stream-style valid/ready byte handshakes.

Parameters:
- OP_WIDTH, 32, operand/result width in bits; multiple of 8; OP_BYTES = OP_WIDTH/8.
- MAX_LEN, 16'hFFFF, largest accepted packet length field; larger lengths are flagged as errors.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- s_axis_tdata  in  8  received byte from uart_rx
- s_axis_tvalid  in  1  received byte valid
- s_axis_tready  out  1  core accepts byte
- m_axis_tdata  out  8  response byte to uart_tx
- m_axis_tvalid  out  1  response byte valid
- m_axis_tready  in  1  uart_tx accepts byte
- busy  out  1  high whenever state != S_OPCODE
- err_o  out  1  one-cycle pulse when a packet is rejected

Behaviour:
- Packet format:
  - byte0 opcode; byte1 reserved (ignored).
  - byte2/byte3 = LEN, little-endian; LEN is the total packet length including the 4 header bytes.
  - Bytes 4..LEN-1 are payload.
- Opcodes: ECHO=8'hEC, ADD=8'hA0, SUB=8'hA1; MUL=8'h88 is optional.
- Transfers happen only on tvalid&&tready; the byte counter increments per accepted input byte.
- States: S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPND, S_RESP, S_DRAIN, S_ERR.
- S_OPCODE/S_RSV/S_LEN_LO/S_LEN_HI: s_axis_tready=1; capture fields in order, one per accepted byte.
- Validation on LEN_HI acceptance, in order:
  - Unknown opcode, LEN<4, or LEN>MAX_LEN -> S_DRAIN. Remaining bytes = LEN-4, floored at 0; if 0 go straight to S_ERR.
  - ECHO with LEN==4 -> S_OPCODE; nothing emitted, no error.
  - ECHO -> S_ECHO.
  - Arithmetic with (LEN-4)==0 or (LEN-4)%OP_BYTES!=0 -> S_DRAIN.
  - Otherwise -> S_OPND.
- S_ECHO: combinational pass-through.
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - After the last payload byte transfers -> S_OPCODE.
- S_OPND: s_axis_tready=1; bytes assemble operands little-endian.
  - First operand loads the accumulator.
  - Each later operand: ADD acc=acc+op; SUB acc=acc-op; MUL acc=acc*op (low OP_WIDTH bits). All results wrap modulo 2^OP_WIDTH.
  - The accumulator update occurs in the cycle the operand's final byte is accepted.
  - After the final payload byte -> S_RESP.
- S_RESP: s_axis_tready=0; emit OP_BYTES result bytes LSB first from a registered output.
  - m_axis_tvalid is held high, with tdata stable, until tready.
  - Then -> S_OPCODE.
- S_DRAIN: s_axis_tready=1; discard the remaining bytes, then -> S_ERR.
- S_ERR: emit a single byte 8'hEE, holding valid until tready.
  - err_o pulses for one cycle on entry to S_ERR.
  - Then -> S_OPCODE.
- m_axis_tvalid=0 and s_axis_tready=0 in any state not listed above as driving them.
- Reset values (rst low, asynchronous):
  - State -> S_OPCODE; all counters, accumulator and captured fields -> 0.
  - m_axis_tvalid=0, m_axis_tdata=0, busy=0, err_o=0, s_axis_tready=0 while asserted.
  - Reset mid-packet abandons the packet silently: no error byte.
- Latency:
  - Arithmetic: first response byte is valid the cycle after the final payload byte is accepted.
  - ECHO: zero-cycle pass-through.
- Backpressure: m_axis_tvalid never drops and m_axis_tdata never changes until the byte is accepted.

Optional Feature:
- ALU_MUL_EN defined: opcode 8'h88 is valid; the product of all operands is truncated to OP_WIDTH (one multiplier, result registered).
- ALU_MUL_EN undefined: 8'h88 is an unknown opcode -> drain + 8'hEE; no multiplier is synthesized.

Decomposition:
- Package uart_alu_pkg holds:
  - state_e enum;
  - opcode localparams OP_ECHO, OP_ADD, OP_SUB, OP_MUL;
  - ERR_BYTE=8'hEE;
  - HDR_BYTES=4.
- One sub-module: uart_alu_datapath (accumulator, operand byte assembler, op select, result serializer), controlled by the FSM in uart_alu_core.

Test Plan:
- ADD: EC-free stream A0 00 0C 00 | 01 00 00 00 | 02 00 00 00 -> tx 03 00 00 00; err_o never pulses.
- SUB wrap: A1 00 0C 00 | 00 00 00 00 | 01 00 00 00 -> tx FF FF FF FF.
- ECHO with m_axis_tready toggling every other cycle: EC 00 07 00 41 42 43 -> tx 41 42 43, order preserved, no byte lost or duplicated.
- Bad opcode: 55 00 06 00 11 22 -> both payload bytes drained; tx EE; err_o one pulse. A following valid ADD packet must then respond correctly.
- Misaligned length: A0 00 07 00 AA BB CC -> tx EE; arithmetic result bytes are never emitted.
- Async reset: assert rst low after 2 operand bytes of an ADD, release, send ADD 05+06 -> tx 0B 00 00 00 only. With ALU_MUL_EN: 88 00 0C 00 03.. 04.. -> tx 0C 00 00 00.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU command core.
// Optional multiply support is enabled by defining ALU_MUL_EN.
package uart_alu_pkg;

   typedef enum logic [3:0] {
      S_OPCODE,
      S_RSV,
      S_LEN_LO,
      S_LEN_HI,
      S_ECHO,
      S_OPND,
      S_RESP,
      S_DRAIN,
      S_ERR
   } state_e;

   localparam logic [7:0] OP_ECHO  = 8'hEC;
   localparam logic [7:0] OP_ADD   = 8'hA0;
   localparam logic [7:0] OP_SUB   = 8'hA1;
   localparam logic [7:0] OP_MUL   = 8'h88;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   localparam int unsigned HDR_BYTES = 4;

   function automatic logic op_known(input logic [7:0] op);
`ifdef ALU_MUL_EN
      return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
`else
      return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_SUB);
`endif
   endfunction

   function automatic logic op_arith(input logic [7:0] op);
      return op_known(op) && (op != OP_ECHO);
   endfunction

endpackage

// File: rtl/uart_alu_datapath.sv
// Accumulator, little-endian operand assembler and result serializer.
// The multiply path exists only when ALU_MUL_EN is defined.
module uart_alu_datapath
   import uart_alu_pkg::*;
#(
   parameter int unsigned OP_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       byte_en,
   input  logic [7:0] byte_in,
   input  logic [7:0] opcode,
   input  logic       shift,
   output logic [7:0] res_byte
);

   localparam int unsigned OP_BYTES = OP_WIDTH / 8;

   logic [OP_WIDTH-1:0] acc_q, acc_d;
   logic [OP_WIDTH-1:0] op_q, op_d;
   logic [OP_WIDTH-1:0] op_full;
   logic [OP_WIDTH-1:0] alu_res;
   logic [7:0]          idx_q, idx_d;
   logic                first_q, first_d;

   // Bytes arrive LSB first and shift in from the top.
   assign op_full  = OP_WIDTH'({byte_in, op_q} >> 8);
   assign res_byte = acc_q[7:0];

   always_comb begin
      alu_res = acc_q;
      unique case (opcode)
         OP_ADD:  alu_res = acc_q + op_full;
         OP_SUB:  alu_res = acc_q - op_full;
`ifdef ALU_MUL_EN
         OP_MUL:  alu_res = acc_q * op_full;
`endif
         default: alu_res = acc_q;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      op_d    = op_q;
      idx_d   = idx_q;
      first_d = first_q;
      if (clear) begin
         acc_d   = '0;
         op_d    = '0;
         idx_d   = '0;
         first_d = 1'b1;
      end else if (byte_en) begin
         op_d = op_full;
         if (idx_q == 8'(OP_BYTES - 1)) begin
            idx_d   = '0;
            first_d = 1'b0;
            acc_d   = first_q ? op_full : alu_res;
         end else begin
            idx_d = idx_q + 8'd1;
         end
      end else if (shift) begin
         acc_d = acc_q >> 8;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         first_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/uart_alu_core.sv
// Packet parser/controller between uart_rx and uart_tx byte streams.
// Define ALU_MUL_EN to accept the multiply opcode.
module uart_alu_core
   import uart_alu_pkg::*;
#(
   parameter int unsigned OP_WIDTH = 32,
   parameter int unsigned MAX_LEN  = 16'hFFFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       busy,
   output logic       err_o
);

   localparam int unsigned OP_BYTES = OP_WIDTH / 8;

   state_e      state_q, state_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [15:0] pay_len_q, pay_len_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   logic        s_rdy;
   logic        s_hs, m_hs;
   logic [15:0] len_full, pay_full;
   logic        len_short, len_bad, misaligned;
   logic        dp_clear, dp_byte_en, dp_shift;
   logic [7:0]  dp_res_byte;

   assign len_full   = {s_axis_tdata, len_lo_q};
   assign pay_full   = len_full - 16'(HDR_BYTES);
   assign len_short  = len_full < 16'(HDR_BYTES);
   assign len_bad    = len_short || (32'(len_full) > MAX_LEN);
   assign misaligned = (32'(pay_full) % OP_BYTES) != 32'd0;

   assign s_hs = s_axis_tvalid && s_rdy;
   assign m_hs = m_axis_tvalid && m_axis_tready;

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      len_lo_d      = len_lo_q;
      pay_len_d     = pay_len_q;
      cnt_d         = cnt_q;
      s_rdy         = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      dp_clear      = 1'b0;
      dp_byte_en    = 1'b0;
      dp_shift      = 1'b0;
      unique case (state_q)
         S_OPCODE: begin
            s_rdy = 1'b1;
            if (s_hs) begin
               opcode_d = s_axis_tdata;
               state_d  = S_RSV;
            end
         end
         S_RSV: begin
            s_rdy = 1'b1;
            if (s_hs) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            s_rdy = 1'b1;
            if (s_hs) begin
               len_lo_d = s_axis_tdata;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            s_rdy = 1'b1;
            if (s_hs) begin
               cnt_d     = '0;
               dp_clear  = 1'b1;
               pay_len_d = len_short ? 16'd0 : pay_full;
               if (!op_known(opcode_q) || len_bad) begin
                  state_d = (len_short || pay_full == 16'd0) ? S_ERR : S_DRAIN;
               end else if (opcode_q == OP_ECHO) begin
                  state_d = (pay_full == 16'd0) ? S_OPCODE : S_ECHO;
               end else if (pay_full == 16'd0) begin
                  state_d = S_ERR;
               end else if (misaligned) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_OPND;
               end
            end
         end
         S_ECHO: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            s_rdy         = m_axis_tready;
            if (s_hs) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == pay_len_q - 16'd1) state_d = S_OPCODE;
            end
         end
         S_OPND: begin
            s_rdy = 1'b1;
            if (s_hs) begin
               dp_byte_en = 1'b1;
               cnt_d      = cnt_q + 16'd1;
               if (cnt_q == pay_len_q - 16'd1) begin
                  cnt_d   = '0;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = dp_res_byte;
            if (m_hs) begin
               dp_shift = 1'b1;
               cnt_d    = cnt_q + 16'd1;
               if (cnt_q == 16'(OP_BYTES - 1)) state_d = S_OPCODE;
            end
         end
         S_DRAIN: begin
            s_rdy = 1'b1;
            if (s_hs) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == pay_len_q - 16'd1) state_d = S_ERR;
            end
         end
         S_ERR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = ERR_BYTE;
            if (m_hs) state_d = S_OPCODE;
         end
         default: state_d = S_OPCODE;
      endcase
   end

   assign err_d = (state_d == S_ERR) && (state_q != S_ERR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_OPCODE;
         opcode_q  <= '0;
         len_lo_q  <= '0;
         pay_len_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         len_lo_q  <= len_lo_d;
         pay_len_q <= pay_len_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   // Ready is forced low while reset is held even though the idle state accepts bytes.
   assign s_axis_tready = s_rdy && rst;
   assign busy          = (state_q != S_OPCODE);
   assign err_o         = err_q;

   uart_alu_datapath #(
      .OP_WIDTH (OP_WIDTH)
   ) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .clear    (dp_clear),
      .byte_en  (dp_byte_en),
      .byte_in  (s_axis_tdata),
      .opcode   (opcode_q),
      .shift    (dp_shift),
      .res_byte (dp_res_byte)
   );

endmodule

// File: tb/tb_uart_alu_core.sv
// Scoreboard bench for uart_alu_core; define ALU_MUL_EN to exercise the multiply opcode.
module tb_uart_alu_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b1;
   logic       busy;
   logic       err_o;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   bit tog_en = 1'b0;
   logic prev_err = 1'b0;
   logic hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;

   logic [7:0] exp_q[$];
   logic [7:0] tx_pkt[$];

   always #5 clk = ~clk;

   uart_alu_core dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .err_o         (err_o)
   );

   always @(posedge clk) begin
      #1;
      if (tog_en) m_axis_tready = ~m_axis_tready;
      else        m_axis_tready = 1'b1;
   end

   // Monitor: pops expected bytes on each output handshake, checks hold under backpressure.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst) begin
         if (err_o) begin
            err_cnt++;
            checks++;
            if (prev_err) begin
               errors++;
               $display("FAIL err_pulse_width got two consecutive cycles required one");
            end
         end
         prev_err = err_o;
         if (hold_pend) begin
            checks++;
            if (!m_axis_tvalid || m_axis_tdata !== hold_data) begin
               errors++;
               $display("FAIL backpressure_hold got valid=%0b data=%02h required valid=1 data=%02h",
                        m_axis_tvalid, m_axis_tdata, hold_data);
            end
         end
         hold_pend = m_axis_tvalid && !m_axis_tready;
         hold_data = m_axis_tdata;
         if (m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte got %02h required none", m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               if (m_axis_tdata !== e) begin
                  errors++;
                  $display("FAIL tx_byte got %02h required %02h", m_axis_tdata, e);
               end
            end
         end
      end else begin
         hold_pend = 1'b0;
         prev_err  = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_axis_tready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got ready=0 required ready=1 byte=%02h", b);
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input bit chk_lat);
      for (int i = 0; i < tx_pkt.size(); i++) send_byte(tx_pkt[i]);
      if (chk_lat) check("resp_latency_valid", {31'd0, m_axis_tvalid}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || busy) begin
         errors++;
         $display("FAIL %s_complete got pending=%0d busy=%0b required pending=0 busy=0",
                  name, exp_q.size(), busy);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_tready"}, {31'd0, s_axis_tready}, 32'd0);
      check({tag, "_m_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
      check({tag, "_m_tdata"}, {24'd0, m_axis_tdata}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_err"}, {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ready", {31'd0, s_axis_tready}, 32'd1);

      // ADD 1 + 2
      e0 = err_cnt;
      push_word(32'h0000_0003);
      tx_pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt(1'b1);
      wait_idle("add");
      check("add_err_pulses", err_cnt - e0, 0);

      // SUB 0 - 1 wraps
      push_word(32'hFFFF_FFFF);
      tx_pkt = {8'hA1, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h00, 8'h00, 8'h00};
      send_pkt(1'b1);
      wait_idle("sub");

      // ECHO with toggling downstream ready
      e0 = err_cnt;
      tog_en = 1'b1;
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h43);
      tx_pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      send_pkt(1'b0);
      wait_idle("echo");
      tog_en = 1'b0;
      check("echo_err_pulses", err_cnt - e0, 0);

      // ECHO with empty payload emits nothing
      e0 = err_cnt;
      tx_pkt = {8'hEC, 8'h00, 8'h04, 8'h00};
      send_pkt(1'b0);
      check("echo_empty_busy", {31'd0, busy}, 32'd0);
      wait_idle("echo_empty");
      check("echo_empty_err_pulses", err_cnt - e0, 0);

      // Unknown opcode drains payload then reports error
      e0 = err_cnt;
      exp_q.push_back(8'hEE);
      tx_pkt = {8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
      send_pkt(1'b0);
      wait_idle("bad_op");
      check("bad_op_err_pulses", err_cnt - e0, 1);

      // Recovery after error
      push_word(32'h0000_0110);
      tx_pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h01, 8'h00, 8'h00};
      send_pkt(1'b1);
      wait_idle("add_after_err");

      // Misaligned arithmetic payload
      e0 = err_cnt;
      exp_q.push_back(8'hEE);
      tx_pkt = {8'hA0, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      send_pkt(1'b0);
      wait_idle("misaligned");
      check("misaligned_err_pulses", err_cnt - e0, 1);

      // Length below header size goes straight to error
      e0 = err_cnt;
      exp_q.push_back(8'hEE);
      tx_pkt = {8'hA0, 8'h00, 8'h02, 8'h00};
      send_pkt(1'b0);
      wait_idle("short_len");
      check("short_len_err_pulses", err_cnt - e0, 1);

      // Reset in the middle of an ADD packet
      tx_pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
      send_pkt(1'b0);
      check("mid_pkt_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #3;
      check_reset_outputs("mid_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      e0 = err_cnt;
      push_word(32'h0000_000B);
      tx_pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                8'h06, 8'h00, 8'h00, 8'h00};
      send_pkt(1'b1);
      wait_idle("add_after_reset");
      check("reset_err_pulses", err_cnt - e0, 0);

      // Multiply opcode: product when enabled, drain + error otherwise
      e0 = err_cnt;
`ifdef ALU_MUL_EN
      push_word(32'h0000_000C);
`else
      exp_q.push_back(8'hEE);
`endif
      tx_pkt = {8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                8'h04, 8'h00, 8'h00, 8'h00};
      send_pkt(1'b0);
      wait_idle("mul");
`ifdef ALU_MUL_EN
      check("mul_err_pulses", err_cnt - e0, 0);
`else
      check("mul_err_pulses", err_cnt - e0, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
